branch_pc_unit: RTL and testbench
=================================

# branch_pc_unit

Program-counter and branch-resolution block for the RV32I single-cycle core. Holds the architectural PC. Each unstalled cycle it consumes the ALU's `zero` and `last_bit` flags and its result, picks the next PC (sequential, branch, JAL, JALR or trap vector), and flags misaligned control transfers. It also keeps a retired-instruction counter. The ALU produces the flags; this block is their consumer.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- TRAP_VEC, 32'h0000_0100, PC loaded on a misaligned-target or reserved-type trap

Ports:
- clk  in  1  core clock, rising-edge active
- rst  in  1  asynchronous, active-low reset
- stall  in  1  1 = hold all state this cycle (memory not ready)
- br_type  in  3  000 none, 001 BEQ, 010 BNE, 011 BLT, 100 BGE, 101 JAL, 110 JALR, 111 reserved
- alu_zero  in  1  ALU `zero` flag (ALU performs SUB for BEQ/BNE)
- alu_last_bit  in  1  ALU bit 0 (ALU performs SLT for BLT/BGE)
- alu_result  in  32  ALU sum rs1+imm, used as the JALR target
- immediate  in  32  sign-extended branch/JAL offset
- pc  out  32  current PC (registered)
- pc_plus4  out  32  pc+4, combinational; the rd write value for JAL/JALR
- redirect  out  1  registered pulse: previous update was a taken branch or jump
- trap  out  1  registered pulse: previous update went to TRAP_VEC
- mepc  out  32  PC of the last trapping instruction (registered)
- instret  out  64  retired-instruction count (registered)

## Operation
- Target: BEQ/BNE/BLT/BGE/JAL use `br_tgt = pc + immediate`. JALR uses `{alu_result[31:1], 1'b0}`. All additions are modulo 2^32.
- Taken condition:
  - BEQ: alu_zero=1
  - BNE: alu_zero=0
  - BLT: alu_last_bit=1
  - BGE: alu_last_bit=0
  - JAL and JALR: always taken
  - none: never taken
- Misalignment: the selected target has `tgt[1:0] != 2'b00` and the transfer is taken. A not-taken branch with a misaligned target does not trap. For JALR, bit 0 is cleared first, so only bit 1 can fault.
- Next-state priority, highest first:
  1. stall=1: all registers hold. redirect and trap clear to 0. instret holds.
  2. br_type=111 or misaligned taken target: pc←TRAP_VEC, mepc←pc, trap←1, redirect←0. instret does not increment.
  3. Taken: pc←target, redirect←1, trap←0, instret+1.
  4. Otherwise: pc←pc+4, redirect←0, trap←0, instret+1.
- Wrap-around:
  - pc+4 from 32'hFFFF_FFFC gives 32'h0000_0000; no fault.
  - instret wraps from 2^64−1 to 0.
- mepc changes only on a trap. It holds across later traps until the next one overwrites it.
- The PC never holds a misaligned value. RESET_PC and TRAP_VEC must be word-aligned; the bench checks this at elaboration.

## Timing
- Every register updates on the rising edge of clk. Inputs must be stable before that edge (single-cycle datapath).
- Latency:
  - pc reflects a decision one edge after the inputs are presented.
  - redirect and trap assert during the cycle after the deciding edge, for exactly one cycle unless the next decision repeats them.
  - pc_plus4 has zero latency from pc.
- Reset:
  - rst=0 forces pc=RESET_PC, redirect=0, trap=0, mepc=0, instret=0 immediately, without waiting for clk.
  - On release, the first update happens on the first rising edge with rst=1.
  - A reset in the middle of a stall or trap cycle drops the pending update.
- Stall: any number of consecutive stall cycles leaves pc, mepc and instret exactly as they were. Decision inputs are re-sampled on the first unstalled edge.
- No internal multi-cycle state: there is no pending transfer across a stall.

## Test plan
- Reset and sequential fetch: assert rst=0 mid-cycle, then release with br_type=000 for 3 edges → pc=0 immediately at assertion, then 4, 8, 12; instret=3; redirect=trap=0 throughout.
- BEQ taken and BLT not taken:
  - pc=0x40, immediate=0xFFFF_FFF0, BEQ, alu_zero=1 → pc=0x30, redirect=1 for one cycle, instret+1.
  - Then BLT with alu_last_bit=0 → pc=0x34, redirect=0.
- JALR bit-0 clear: alu_result=0x0000_2001, JALR → pc=0x2000, redirect=1, no trap. Separately, pc_plus4 equals the old pc+4 before the edge.
- Misaligned trap:
  - pc=0x80, JAL, immediate=0x6 → pc=0x100, trap=1 for one cycle, mepc=0x80, instret unchanged.
  - BNE with alu_zero=1 and immediate=0x6 → no trap, pc=0x84.
- Stall and reserved type:
  - Hold stall=1 for 4 cycles while driving a taken JAL → pc, instret and mepc unchanged; redirect=0.
  - Then drive br_type=111 unstalled → pc=TRAP_VEC, trap=1.
- Wrap: pc=0xFFFF_FFFC, br_type=000 → pc=0x0000_0000, no trap. Force instret to 2^64−1 → next retire gives instret=0.

Source files
------------

// File: rtl/branch_pc_unit.sv
// Program counter and branch resolution for the RV32I single-cycle core.
// Chooses the next PC from the ALU flags, traps on misaligned or reserved transfers, and counts retired instructions.
module branch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [2:0]  br_type,
    input  logic        alu_zero,
    input  logic        alu_last_bit,
    input  logic [31:0] alu_result,
    input  logic [31:0] immediate,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        redirect,
    output logic        trap,
    output logic [31:0] mepc,
    output logic [63:0] instret
);

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_BEQ  = 3'b001;
    localparam logic [2:0] BR_BNE  = 3'b010;
    localparam logic [2:0] BR_BLT  = 3'b011;
    localparam logic [2:0] BR_BGE  = 3'b100;
    localparam logic [2:0] BR_JAL  = 3'b101;
    localparam logic [2:0] BR_JALR = 3'b110;
    localparam logic [2:0] BR_RSVD = 3'b111;

    logic [31:0] br_tgt;
    logic [31:0] jalr_tgt;
    logic [31:0] target;
    logic        taken;
    logic        misaligned;
    logic        take_trap;
    logic        unused_alu_bit0;

    // JALR discards bit 0 of the computed address, so only bit 1 can fault.
    assign unused_alu_bit0 = alu_result[0];
    assign pc_plus4        = pc + 32'd4;
    assign br_tgt          = pc + immediate;
    assign jalr_tgt        = {alu_result[31:1], 1'b0};

    always_comb begin
        taken  = 1'b0;
        target = br_tgt;
        case (br_type)
            BR_NONE: taken = 1'b0;
            BR_BEQ:  taken = alu_zero;
            BR_BNE:  taken = ~alu_zero;
            BR_BLT:  taken = alu_last_bit;
            BR_BGE:  taken = ~alu_last_bit;
            BR_JAL:  taken = 1'b1;
            BR_JALR: begin
                taken  = 1'b1;
                target = jalr_tgt;
            end
            BR_RSVD: taken = 1'b0;
            default: taken = 1'b0;
        endcase
    end

    // A not-taken branch never faults, whatever its target would have been.
    assign misaligned = taken && (target[1:0] != 2'b00);
    assign take_trap  = (br_type == BR_RSVD) || misaligned;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc       <= RESET_PC;
            redirect <= 1'b0;
            trap     <= 1'b0;
            mepc     <= 32'h0000_0000;
            instret  <= 64'd0;
        end else if (stall) begin
            redirect <= 1'b0;
            trap     <= 1'b0;
        end else if (take_trap) begin
            pc       <= TRAP_VEC;
            mepc     <= pc;
            trap     <= 1'b1;
            redirect <= 1'b0;
        end else if (taken) begin
            pc       <= target;
            redirect <= 1'b1;
            trap     <= 1'b0;
            instret  <= instret + 64'd1;
        end else begin
            pc       <= pc_plus4;
            redirect <= 1'b0;
            trap     <= 1'b0;
            instret  <= instret + 64'd1;
        end
    end

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed bench for branch_pc_unit: reset, sequential fetch, branches, JALR, traps, stall and wrap-around.
module tb_branch_pc_unit;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TB_TRAP_VEC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [2:0]  br_type;
    logic        alu_zero;
    logic        alu_last_bit;
    logic [31:0] alu_result;
    logic [31:0] immediate;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        redirect;
    logic        trap;
    logic [31:0] mepc;
    logic [63:0] instret;

    int checks = 0;
    int errors = 0;

    branch_pc_unit #(
        .RESET_PC(TB_RESET_PC),
        .TRAP_VEC(TB_TRAP_VEC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .br_type(br_type),
        .alu_zero(alu_zero),
        .alu_last_bit(alu_last_bit),
        .alu_result(alu_result),
        .immediate(immediate),
        .pc(pc),
        .pc_plus4(pc_plus4),
        .redirect(redirect),
        .trap(trap),
        .mepc(mepc),
        .instret(instret)
    );

    always #5 clk = ~clk;

    initial begin
        if (TB_RESET_PC[1:0] != 2'b00 || TB_TRAP_VEC[1:0] != 2'b00) begin
            $display("FAIL param_align RESET_PC=%h TRAP_VEC=%h must be word-aligned", TB_RESET_PC, TB_TRAP_VEC);
            $fatal(1, "misaligned parameters");
        end
    end

    task automatic drive(input logic s, input logic [2:0] t, input logic z, input logic lb,
                         input logic [31:0] res, input logic [31:0] imm);
        stall        = s;
        br_type      = t;
        alu_zero     = z;
        alu_last_bit = lb;
        alu_result   = res;
        immediate    = imm;
    endtask

    // Advance one rising edge and settle 1 ns past it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string name, input logic [31:0] e_pc, input logic e_redir,
                                input logic e_trap, input logic [31:0] e_mepc, input logic [63:0] e_instret);
        checks++;
        if (pc !== e_pc) begin errors++; $display("FAIL %s pc: got %h want %h", name, pc, e_pc); end
        checks++;
        if (redirect !== e_redir) begin errors++; $display("FAIL %s redirect: got %b want %b", name, redirect, e_redir); end
        checks++;
        if (trap !== e_trap) begin errors++; $display("FAIL %s trap: got %b want %b", name, trap, e_trap); end
        checks++;
        if (mepc !== e_mepc) begin errors++; $display("FAIL %s mepc: got %h want %h", name, mepc, e_mepc); end
        checks++;
        if (instret !== e_instret) begin errors++; $display("FAIL %s instret: got %0d want %0d", name, instret, e_instret); end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        tick();
        // Assert reset mid-cycle; outputs must respond without a clock edge.
        #3;
        rst = 1'b0;
        #1;
        expect_state("reset_async", 32'h0, 1'b0, 1'b0, 32'h0, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        tick(); expect_state("seq_1", 32'h4, 1'b0, 1'b0, 32'h0, 64'd1);
        tick(); expect_state("seq_2", 32'h8, 1'b0, 1'b0, 32'h0, 64'd2);
        tick(); expect_state("seq_3", 32'hC, 1'b0, 1'b0, 32'h0, 64'd3);
    endtask

    task automatic test_beq_blt();
        drive(1'b0, 3'b101, 1'b0, 1'b0, 32'h0, 32'h0000_0034);
        tick(); expect_state("jal_to_40", 32'h40, 1'b1, 1'b0, 32'h0, 64'd4);
        drive(1'b0, 3'b001, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFF0);
        tick(); expect_state("beq_taken", 32'h30, 1'b1, 1'b0, 32'h0, 64'd5);
        drive(1'b0, 3'b011, 1'b1, 1'b0, 32'h0, 32'h0000_0100);
        tick(); expect_state("blt_not_taken", 32'h34, 1'b0, 1'b0, 32'h0, 64'd6);
    endtask

    task automatic test_jalr();
        drive(1'b0, 3'b110, 1'b0, 1'b0, 32'h0000_2001, 32'h0000_0010);
        #1;
        checks++;
        if (pc_plus4 !== 32'h38) begin errors++; $display("FAIL jalr_pc_plus4: got %h want %h", pc_plus4, 32'h38); end
        tick(); expect_state("jalr_bit0", 32'h2000, 1'b1, 1'b0, 32'h0, 64'd7);
        checks++;
        if (pc_plus4 !== 32'h2004) begin errors++; $display("FAIL jalr_new_plus4: got %h want %h", pc_plus4, 32'h2004); end
        drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
        tick(); expect_state("redirect_pulse_end", 32'h2004, 1'b0, 1'b0, 32'h0, 64'd8);
    endtask

    task automatic test_misaligned();
        drive(1'b0, 3'b101, 1'b0, 1'b0, 32'h0, 32'hFFFF_E07C);
        tick(); expect_state("jal_to_80", 32'h80, 1'b1, 1'b0, 32'h0, 64'd9);
        drive(1'b0, 3'b101, 1'b0, 1'b0, 32'h0, 32'h0000_0006);
        tick(); expect_state("jal_misaligned", 32'h100, 1'b0, 1'b1, 32'h80, 64'd9);
        drive(1'b0, 3'b101, 1'b0, 1'b0, 32'h0, 32'hFFFF_FF80);
        tick(); expect_state("trap_pulse_end", 32'h80, 1'b1, 1'b0, 32'h80, 64'd10);
        drive(1'b0, 3'b010, 1'b1, 1'b0, 32'h0, 32'h0000_0006);
        tick(); expect_state("bne_nt_misaligned", 32'h84, 1'b0, 1'b0, 32'h80, 64'd11);
        drive(1'b0, 3'b110, 1'b0, 1'b0, 32'h0000_2003, 32'h0);
        tick(); expect_state("jalr_bit1_trap", 32'h100, 1'b0, 1'b1, 32'h84, 64'd11);
    endtask

    task automatic test_stall_reserved();
        drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
        tick(); expect_state("seq_104", 32'h104, 1'b0, 1'b0, 32'h84, 64'd12);
        drive(1'b1, 3'b101, 1'b0, 1'b0, 32'h0, 32'h0000_0008);
        for (int i = 0; i < 4; i++) begin
            tick(); expect_state($sformatf("stall_%0d", i), 32'h104, 1'b0, 1'b0, 32'h84, 64'd12);
        end
        drive(1'b0, 3'b111, 1'b0, 1'b0, 32'h0, 32'h0000_0008);
        tick(); expect_state("reserved_trap", TB_TRAP_VEC, 1'b0, 1'b1, 32'h104, 64'd12);
        drive(1'b0, 3'b111, 1'b0, 1'b0, 32'h0, 32'h0);
        tick(); expect_state("reserved_repeat", TB_TRAP_VEC, 1'b0, 1'b1, 32'h100, 64'd12);
    endtask

    task automatic test_wrap();
        drive(1'b0, 3'b101, 1'b0, 1'b0, 32'h0, 32'hFFFF_FEFC);
        tick(); expect_state("jal_to_top", 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h100, 64'd13);
        drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
        tick(); expect_state("pc_wrap", 32'h0, 1'b0, 1'b0, 32'h100, 64'd14);
        drive(1'b1, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
        force dut.instret = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        release dut.instret;
        #1;
        expect_state("instret_forced", 32'h0, 1'b0, 1'b0, 32'h100, 64'hFFFF_FFFF_FFFF_FFFF);
        drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
        tick(); expect_state("instret_wrap", 32'h4, 1'b0, 1'b0, 32'h100, 64'd0);
    endtask

    task automatic test_reset_drops_trap();
        drive(1'b0, 3'b111, 1'b0, 1'b0, 32'h0, 32'h0);
        #3;
        rst = 1'b0;
        #1;
        expect_state("reset_mid_trap", TB_RESET_PC, 1'b0, 1'b0, 32'h0, 64'd0);
        tick();
        expect_state("reset_held_edge", TB_RESET_PC, 1'b0, 1'b0, 32'h0, 64'd0);
        drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        tick(); expect_state("post_reset_seq", 32'h4, 1'b0, 1'b0, 32'h0, 64'd1);
    endtask

    initial begin
        test_reset();
        test_beq_blt();
        test_jalr();
        test_misaligned();
        test_stall_reserved();
        test_wrap();
        test_reset_drops_trap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
